// File: rtl/rl_pkg.sv
// ----------------------------------------------------------------------------
// rl_pkg
// Shared definitions for the Q-learning datapath blocks.
//   Q_WIDTH_DEFAULT    default width of a signed Q value
//   LFSR_TAPS          Galois feedback mask for the 16-bit LFSR
//   LFSR_DEFAULT_SEED  seed used when a caller supplies zero
//   fsm_state_t        state encoding of the epsilon-greedy selector
//   act_width(n)       bits needed to index n actions, never less than 1
// ----------------------------------------------------------------------------
package rl_pkg;

  localparam int          Q_WIDTH_DEFAULT   = 16;
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_HOLD   = 2'd3
  } fsm_state_t;

  function automatic int act_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rl_lfsr16.sv
// ----------------------------------------------------------------------------
// rl_lfsr16
// Free-running 16-bit Galois LFSR. Loads the seed while rst_n is low and
// advances on every rising clock edge afterwards. A zero seed would lock the
// register at zero, so it is replaced by LFSR_DEFAULT_SEED.
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   seed   in   16  reset value (zero maps to LFSR_DEFAULT_SEED)
//   state  out  16  current LFSR value, range 1..65535
// ----------------------------------------------------------------------------
module rl_lfsr16
  import rl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] seed_eff;

  assign seed_eff = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

  // Galois form: shift right, fold the taps in when the outgoing bit is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= seed_eff;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/epsilon_greedy_policy.sv
// ----------------------------------------------------------------------------
// epsilon_greedy_policy
// Epsilon-greedy action selector. Takes one state's Q-vector, scans it one
// action per cycle for the greedy action and its Q value, then uses an LFSR
// sample captured at accept time to choose between exploring (random action)
// and exploiting (greedy action). The result is held until consumed.
// Ports:
//   clk          in   1                  rising-edge clock
//   rst_n        in   1                  asynchronous active-low reset
//   in_valid     in   1                  request valid
//   in_ready     out  1                  high only while idle
//   q_values     in   N_ACTIONS*Q_WIDTH  action i at [i*Q_WIDTH +: Q_WIDTH]
//   epsilon      in   16                 unsigned exploration threshold
//   greedy_only  in   1                  force exploit
//   out_valid    out  1                  result valid
//   out_ready    in   1                  consumer accepts result
//   next_action  out  ACT_W              selected action
//   max_q        out  Q_WIDTH            maximum Q of the vector
//   explored     out  1                  next_action came from the random draw
// ----------------------------------------------------------------------------
module epsilon_greedy_policy
  import rl_pkg::*;
#(
  parameter int          N_ACTIONS = 4,
  parameter int          Q_WIDTH   = Q_WIDTH_DEFAULT,
  parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED,
  localparam int         ACT_W     = act_width(N_ACTIONS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_ACTIONS*Q_WIDTH-1:0] q_values,
  input  logic [15:0]                  epsilon,
  input  logic                         greedy_only,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACT_W-1:0]             next_action,
  output logic signed [Q_WIDTH-1:0]    max_q,
  output logic                         explored
);

  localparam logic [15:0]      SEED_EFF = (LFSR_SEED == 16'h0000) ? LFSR_DEFAULT_SEED : LFSR_SEED;
  localparam logic [ACT_W-1:0] LAST_IDX = ACT_W'(N_ACTIONS - 1);

  fsm_state_t                state;
  logic [15:0]               lfsr_state;

  // Request registers, loaded in the IDLE accept cycle only.
  logic signed [Q_WIDTH-1:0] q_req [N_ACTIONS];
  logic [15:0]               eps_req;
  logic [15:0]               sample_req;
  logic                      greedy_req;

  logic [ACT_W-1:0]          idx;
  logic [ACT_W-1:0]          best_idx;
  logic signed [Q_WIDTH-1:0] best_q;
  logic signed [Q_WIDTH-1:0] cur_q;
  logic                      explore;
  logic [ACT_W-1:0]          rand_act;

  rl_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED_EFF),
    .state (lfsr_state)
  );

  // The raw draw spans 0..2**ACT_W-1, which is below 2*N_ACTIONS, so one
  // conditional subtraction always lands inside 0..N_ACTIONS-1.
  function automatic logic [ACT_W-1:0] fold_action(input logic [ACT_W-1:0] r);
    if ({1'b0, r} >= (ACT_W+1)'(N_ACTIONS)) begin
      return r - ACT_W'(N_ACTIONS);
    end
    return r;
  endfunction

  // Q value under the scan pointer.
  always_comb begin
    cur_q = q_req[0];
    for (int i = 1; i < N_ACTIONS; i++) begin
      if (idx == ACT_W'(i)) begin
        cur_q = q_req[i];
      end
    end
  end

  assign explore  = !greedy_req && (sample_req <= eps_req);
  assign rand_act = fold_action(sample_req[ACT_W-1:0]);

  // ---- Stage: request capture and argmax scan (data path, no reset) ----
  // Strict signed greater-than keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      for (int i = 0; i < N_ACTIONS; i++) begin
        q_req[i] <= q_values[i*Q_WIDTH +: Q_WIDTH];
      end
      eps_req    <= epsilon;
      greedy_req <= greedy_only;
      sample_req <= lfsr_state;
      best_q     <= q_values[Q_WIDTH-1:0];
      best_idx   <= '0;
    end else if (state == ST_SCAN && cur_q > best_q) begin
      best_q   <= cur_q;
      best_idx <= idx;
    end
  end

  // ---- Stage: control FSM and registered result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      next_action <= '0;
      max_q       <= '0;
      explored    <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            idx      <= ACT_W'(1);
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (idx == LAST_IDX) begin
            state <= ST_DECIDE;
          end else begin
            idx <= idx + ACT_W'(1);
          end
        end
        ST_DECIDE: begin
          next_action <= explore ? rand_act : best_idx;
          max_q       <= best_q;
          explored    <= explore;
          out_valid   <= 1'b1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_epsilon_greedy_policy.sv
module tb_epsilon_greedy_policy;

  typedef struct packed {
    logic [1:0]  act;
    logic [15:0] mq;
    logic        expl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  // 4-action instance
  logic        in_valid;
  logic        in_ready;
  logic [63:0] q_values;
  logic [15:0] epsilon;
  logic        greedy_only;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  next_action;
  logic [15:0] max_q;
  logic        explored;

  // 3-action instance
  logic        in_valid3;
  logic        in_ready3;
  logic [47:0] q_values3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  next_action3;
  logic [15:0] max_q3;
  logic        explored3;

  logic [15:0] lfsr_m;
  exp_t        sb[$];
  exp_t        sb3[$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  epsilon_greedy_policy #(.N_ACTIONS(4), .Q_WIDTH(16), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .q_values(q_values), .epsilon(epsilon), .greedy_only(greedy_only),
    .out_valid(out_valid), .out_ready(out_ready), .next_action(next_action),
    .max_q(max_q), .explored(explored)
  );

  epsilon_greedy_policy #(.N_ACTIONS(3), .Q_WIDTH(16), .LFSR_SEED(16'hACE1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .q_values(q_values3), .epsilon(epsilon), .greedy_only(greedy_only),
    .out_valid(out_valid3), .out_ready(out_ready3), .next_action(next_action3),
    .max_q(max_q3), .explored(explored3)
  );

  // Reference LFSR, restarted from the seed whenever reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  function automatic exp_t model(input logic [63:0] q, input int n, input logic [15:0] eps,
                                 input logic g, input logic [15:0] s);
    exp_t               e;
    int                 best;
    logic signed [15:0] bq;
    logic signed [15:0] v;
    logic [1:0]         r;
    best = 0;
    bq   = q[15:0];
    for (int i = 1; i < n; i++) begin
      v = q[i*16 +: 16];
      if (v > bq) begin
        bq   = v;
        best = i;
      end
    end
    r = s[1:0];
    if (int'(r) >= n) r = 2'(int'(r) - n);
    e.expl = !g && (s <= eps);
    e.act  = e.expl ? r : 2'(best);
    e.mq   = bq;
    return e;
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Present a request to the 4-action instance; returns at accept edge + 1.
  task automatic send(input logic [63:0] q, input logic [15:0] eps, input logic g);
    check("in_ready_idle", in_ready, 1);
    q_values    = q;
    epsilon     = eps;
    greedy_only = g;
    in_valid    = 1'b1;
    sb.push_back(model(q, 4, eps, g, lfsr_m));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result and compare it with the scoreboard head.
  task automatic wait_result(input string tag, output int lat, output exp_t e);
    lat = 0;
    e   = '0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_next_action"}, next_action, e.act);
      check({tag, "_max_q"}, max_q, e.mq);
      check({tag, "_explored"}, explored, e.expl);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_back"}, in_ready, 1);
    check({tag, "_out_valid_low"}, out_valid, 0);
  endtask

  initial begin
    int         lat;
    exp_t       e;
    logic [3:0] seen;
    logic [2:0] seen3;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; q_values = '0;
    epsilon = '0; greedy_only = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b1; q_values3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_next_action", next_action, 0);
    check("rst_max_q", max_q, 0);
    check("rst_explored", explored, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie on 40 resolves to the lower index; latency is N_ACTIONS cycles.
    send(pack4(10, 40, -5, 40), 16'h0000, 1'b1);
    check("t1_in_ready_busy", in_ready, 0);
    wait_result("t1", lat, e);
    check("t1_latency", lat, 4);
    consume("t1");

    // All-negative vector, epsilon 0 never explores.
    send(pack4(-7, -3, -9, -100), 16'h0000, 1'b0);
    wait_result("t2", lat, e);
    consume("t2");

    // greedy_only overrides a maximal epsilon.
    send(pack4(5, 1, 5, 9), 16'hFFFF, 1'b1);
    wait_result("t2b", lat, e);
    consume("t2b");

    // Maximal epsilon always explores; action follows the LFSR draw.
    seen = '0;
    for (int i = 0; i < 200; i++) begin
      send(pack4(i, 100, -i, 7), 16'hFFFF, 1'b0);
      wait_result("t3", lat, e);
      seen[next_action] = 1'b1;
      consume("t3");
    end
    check("t3_all_actions", seen, 4'hF);

    // Back-pressure: result held, new in_valid ignored while busy.
    send(pack4(1, 2, 3, 4), 16'h8000, 1'b0);
    wait_result("t4", lat, e);
    in_valid = 1'b1;
    q_values = pack4(900, -900, 901, 5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_in_ready", in_ready, 0);
      check("t4_hold_action", next_action, e.act);
      check("t4_hold_max_q", max_q, e.mq);
      check("t4_hold_explored", explored, e.expl);
    end
    in_valid = 1'b0;
    consume("t4");
    check("t4_after_action", next_action, e.act);
    check("t4_after_max_q", max_q, e.mq);

    // Three-action build: random draws of 3 fold back to 0.
    seen3 = '0;
    for (int i = 0; i < 40; i++) begin
      check("t5_in_ready", in_ready3, 1);
      q_values3   = {16'(i), 16'(2), 16'(-1)};
      epsilon     = 16'hFFFF;
      greedy_only = 1'b0;
      in_valid3   = 1'b1;
      sb3.push_back(model({16'h0000, q_values3}, 3, 16'hFFFF, 1'b0, lfsr_m));
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      lat = 0;
      while (out_valid3 !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check("t5_out_valid", out_valid3, 1);
      check("t5_latency", lat, 3);
      e = sb3.pop_front();
      check("t5_next_action", next_action3, e.act);
      check("t5_max_q", max_q3, e.mq);
      check("t5_explored", explored3, e.expl);
      check("t5_range", (next_action3 <= 2'd2), 1);
      if (next_action3 <= 2'd2) seen3[next_action3] = 1'b1;
      @(posedge clk); #1;
    end
    check("t5_all_actions", seen3, 3'b111);

    // Reset mid-scan drops the request and restarts the LFSR.
    send(pack4(3, 8, 1, 2), 16'hFFFF, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_next_action", next_action, 0);
    check("t6_max_q", max_q, 0);
    check("t6_explored", explored, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(pack4(3, 8, 1, 2), 16'hFFFF, 1'b0);
    wait_result("t6", lat, e);
    // First draw after reset is the seed 16'hACE1, low bits 01.
    check("t6_seed_action", next_action, 1);
    check("t6_latency", lat, 4);
    consume("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
